// File: rtl/demux1x4_stream.sv
// demux1x4_stream: registered 1-to-4 stream demultiplexer.
// Each item goes to the channel named by its select code. Each channel has a
// single-entry holding register. Items whose select has bit 2 set are consumed
// and counted in a saturating drop counter.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready.
// A producer holds valid and its payload steady until that edge. in_ready is
// computed from the select code and the destination channel's state only. It
// never looks at in_valid. out_valid[k] is a registered flag. out_data{k}
// changes only when channel k loads a new item.
//
// Channel k has two states, EMPTY and FULL, and out_valid[k] is that state.
module demux1x4_stream #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [2:0]    sel,
    output logic [3:0]    out_valid,
    input  logic [3:0]    out_ready,
    output logic [DW-1:0] out_data0,
    output logic [DW-1:0] out_data1,
    output logic [DW-1:0] out_data2,
    output logic [DW-1:0] out_data3,
    output logic [CW-1:0] drop_cnt
);

    localparam logic [CW-1:0] DROP_MAX = '1;

    logic [DW-1:0] data_q [4];
    logic [3:0]    valid_q;
    logic [3:0]    valid_d;
    logic [3:0]    load;
    logic          in_fire;
    logic          drop_fire;

    // Acceptance: drops are always taken. A channel takes an item when it is
    // empty or is being drained on this same edge.
    always_comb begin
        in_ready = 1'b1;
        if (!sel[2]) begin
            in_ready = !valid_q[sel[1:0]] || out_ready[sel[1:0]];
        end
    end

    assign in_fire   = in_valid && in_ready;
    assign drop_fire = in_fire && sel[2];

    // Per-channel load strobes and next occupancy. A load wins over a drain
    // on the same edge, so a FULL channel stays FULL with the new item.
    always_comb begin
        load    = 4'b0000;
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            load[k] = in_fire && !sel[2] && (sel[1:0] == 2'(k));
            if (load[k]) begin
                valid_d[k] = 1'b1;
            end else if (out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload holding registers. Each one loads only on a transfer into its own channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    // Saturating drop counter. It clears only on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_fire && (drop_cnt != DROP_MAX)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

endmodule

// File: tb/tb_demux1x4_stream.sv
// Bench for demux1x4_stream. Two instances share the same stimulus: one with
// the default 8-bit drop counter and one with a 2-bit counter to show
// saturation. The reference model is one FIFO of accepted items per channel,
// plus a plain count of dropped items.
module tb_demux1x4_stream;

    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [2:0]    sel;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [DW-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [7:0]    drop_cnt;

    logic          s_in_ready;
    logic [3:0]    s_out_valid;
    logic [DW-1:0] s_data0, s_data1, s_data2, s_data3;
    logic [1:0]    s_drop_cnt;

    demux1x4_stream #(.DW(DW), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .sel(sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1),
        .out_data2(out_data2), .out_data3(out_data3),
        .drop_cnt(drop_cnt)
    );

    demux1x4_stream #(.DW(DW), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .sel(sel),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data0(s_data0), .out_data1(s_data1),
        .out_data2(s_data2), .out_data3(s_data3),
        .drop_cnt(s_drop_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: expected contents of each channel in acceptance order
    logic [DW-1:0] exp_q [4][$];
    int            drops;
    int            n_checks;
    int            n_pass;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    function automatic logic [DW-1:0] chan_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    // Compare every visible output against the scoreboard.
    task automatic check_outputs();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(exp_q[k].size() != 0));
            check($sformatf("sat.out_valid[%0d]", k), 32'(s_out_valid[k]), 32'(exp_q[k].size() != 0));
            if (exp_q[k].size() != 0) begin
                check($sformatf("out_data%0d", k), 32'(chan_data(k)), 32'(exp_q[k][0]));
            end
        end
        check("drop_cnt", 32'(drop_cnt), 32'(sat(drops, 255)));
        check("sat.drop_cnt", 32'(s_drop_cnt), 32'(sat(drops, 3)));
    endtask

    // Driver: one cycle of stimulus with a pre-edge check and a model update.
    task automatic step(input bit iv, input logic [2:0] s, input logic [DW-1:0] d,
                        input logic [3:0] ordy);
        bit exp_rdy;
        @(negedge clk);
        in_valid  = iv;
        sel       = s;
        in_data   = d;
        out_ready = ordy;
        #1;
        check_outputs();
        exp_rdy = s[2] ? 1'b1 : ((exp_q[s[1:0]].size() == 0) || ordy[s[1:0]]);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("sat.in_ready", 32'(s_in_ready), 32'(exp_rdy));
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (ordy[k] && exp_q[k].size() != 0) begin
                void'(exp_q[k].pop_front());
            end
        end
        if (iv && exp_rdy) begin
            if (s[2]) drops++;
            else      exp_q[s[1:0]].push_back(d);
        end
    endtask

    task automatic idle(input logic [3:0] ordy);
        step(1'b0, 3'b000, '0, ordy);
    endtask

    // Assert reset between clock edges and check that it takes effect at once.
    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst out_data0", 32'(out_data0), 32'h0);
        check("rst out_data1", 32'(out_data1), 32'h0);
        check("rst out_data2", 32'(out_data2), 32'h0);
        check("rst out_data3", 32'(out_data3), 32'h0);
        check("rst drop_cnt", 32'(drop_cnt), 32'h0);
        check("rst sat.drop_cnt", 32'(s_drop_cnt), 32'h0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        drops = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        drops     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        sel       = 3'b000;
        in_data   = '0;
        out_ready = 4'b0000;
        #12;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset drop_cnt", 32'(drop_cnt), 32'h0);
        check("reset out_data0", 32'(out_data0), 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;

        // One item to each channel, all consumers ready
        step(1'b1, 3'd0, 8'hA1, 4'hF);
        step(1'b1, 3'd1, 8'hB2, 4'hF);
        step(1'b1, 3'd2, 8'hC3, 4'hF);
        step(1'b1, 3'd3, 8'hD4, 4'hF);
        #1 check("d4 on ch3", 32'(out_data3), 32'hD4);
        idle(4'hF);
        idle(4'hF);

        // Channel 2 stalled: second item waits, then swaps in on the drain edge
        step(1'b1, 3'd2, 8'h11, 4'b1011);
        step(1'b1, 3'd2, 8'h22, 4'b1011);
        #1 check("ch2 holds 11", 32'(out_data2), 32'h11);
        step(1'b1, 3'd2, 8'h22, 4'b1111);
        #1 check("ch2 swapped to 22", 32'(out_data2), 32'h22);
        check("ch2 still valid", 32'(out_valid[2]), 32'h1);
        idle(4'hF);
        idle(4'hF);

        // Channel 1 stalled and full does not block channel 3
        step(1'b1, 3'd1, 8'h33, 4'b1101);
        step(1'b1, 3'd3, 8'h55, 4'b1101);
        #1 check("ch3 gets 55", 32'(out_data3), 32'h55);
        check("ch1 keeps 33", 32'(out_data1), 32'h33);
        idle(4'b1101);
        idle(4'hF);
        idle(4'hF);

        // Five drops: counter reaches 5, the 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'b100 + 3'(i % 4), 8'($urandom), 4'hF);
        end
        idle(4'hF);
        check("drop_cnt five", 32'(drop_cnt), 32'd5);
        check("sat drop_cnt three", 32'(s_drop_cnt), 32'd3);

        // Channels 0 and 3 full and stalled, then reset between edges
        step(1'b1, 3'd0, 8'h61, 4'b0110);
        step(1'b1, 3'd3, 8'h62, 4'b0110);
        idle(4'b0110);
        async_reset();
        step(1'b1, 3'd0, 8'h7E, 4'hF);
        #1 check("ch0 gets 7E", 32'(out_data0), 32'h7E);
        check("ch0 valid after reset", 32'(out_valid[0]), 32'h1);
        idle(4'hF);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                 4'($urandom) | 4'($urandom));
        end
        for (int i = 0; i < 3; i++) idle(4'hF);
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux1x4_stream.md
Name: demux1x4_stream

Overview:
- Registered 1-to-4 stream demultiplexer: the distribution side of the team's 4:1 select logic.
- Routes each input item to one of four output channels chosen by a per-item select code, using valid/ready handshakes.
- Each output channel has a single-entry holding register; items with an out-of-range select are consumed and counted as drops.
- Sits between a single producer and four independent consumers.

Parameters:
- DW, 8, data width of in_data and each out_data
- CW, 8, width of drop_cnt (saturating)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer offers an item
- in_ready  output  1  block accepts the offered item this cycle
- in_data  input  DW  item payload
- sel  input  3  destination code, qualified by in_valid: 3'b000..3'b011 selects channel 0..3; 3'b1?? means drop
- out_valid  output  4  bit k: channel k holds an item
- out_ready  input  4  bit k: consumer k takes the item
- out_data0..out_data3  output  DW each  channel payload registers
- drop_cnt  output  CW  count of dropped items

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): out_valid=4'b0000, out_data0..3=0, drop_cnt=0. in_ready follows its combinational equation below, so with out_valid=0 it is 1 whenever sel is valid.
- Reset asserted mid-operation: held items are discarded with no ordering guarantee; the first post-reset transfer behaves as from idle.
- Transfers:
  - Input transfer occurs on a rising edge with in_valid && in_ready.
  - Output transfer on channel k occurs on a rising edge with out_valid[k] && out_ready[k].
- Channel k state: EMPTY (out_valid[k]=0) or FULL (out_valid[k]=1).
  - EMPTY -> FULL on an input transfer with sel=k.
  - FULL -> EMPTY on an output transfer with no simultaneous input transfer to k.
  - FULL stays FULL with new data when an output transfer and an input transfer to k occur on the same edge. This gives full throughput: 1 item per cycle per channel.
- in_ready equation:
  - sel[2]=1: in_ready=1.
  - Otherwise: in_ready = !out_valid[sel[1:0]] || out_ready[sel[1:0]].
  - in_ready never depends on in_valid.
- Latency: an item accepted at edge N appears on out_data{k} with out_valid[k]=1 immediately after edge N. There is no combinational in_data-to-out_data path.
- Output stability: while out_valid[k] && !out_ready[k], out_data{k} holds its value. out_data{k} changes only on an input transfer to k.
- Ordering: items to the same channel leave in acceptance order. Channels are independent; a stalled channel never blocks traffic to other channels or drops.
- Drop: an input transfer with sel[2]=1 writes no channel and increments drop_cnt by 1. drop_cnt saturates at 2^CW-1 and clears only on reset.
- X on sel while in_valid=0 must not change state. sel and in_data are sampled only on transfer edges.

Test Plan:
- Reset, then send data 0xA1,0xB2,0xC3,0xD4 with sel 0,1,2,3 in consecutive cycles, all out_ready=1 -> each out_valid[k] pulses for 1 cycle one edge after acceptance with the matching data; in_ready stays 1.
- out_ready[2]=0; send 0x11 then 0x22 to sel=2 -> 0x11 held and stable on out_data2; in_ready=0 on the second item. Raise out_ready[2] -> 0x11 leaves and 0x22 loads on the same edge; out_valid[2] remains 1.
- Channel 1 stalled and full; send 0x55 to sel=3 -> accepted immediately and appears on out_data3 the next cycle; channel 1 contents unchanged.
- Send 5 items with sel=3'b100..3'b111 -> in_ready=1 throughout, no out_valid asserts, drop_cnt=5. With CW=2 and 5 drops -> drop_cnt saturates at 3.
- Channels 0 and 3 full and stalled; assert rst_n=0 between clock edges -> out_valid=0, out_data0..3=0, drop_cnt=0 immediately. After release, item 0x7E to sel=0 arrives one cycle later.
- Continuous random traffic with random out_ready for 10k cycles -> scoreboard confirms per-channel order and no loss or duplication, and the drop count matches the number of sel[2]=1 transfers.
